fetch_pc_stage: RTL and testbench

Fetch stage of the pipelined MIPS CPU: holds the architectural fetch PC (pc_F), checks it against instruction-memory bounds and alignment, and owns the F/D pipeline register. It is fed by the next-PC unit (npc_in) and returns pc_F to it. It supplies IR_D, pc4_D and pc8_D to decode and to the next-PC unit. It also marks the delay-slot (BD) bit for the instruction entering D and applies the stall, exception-redirect and eret rules.

---
 rtl/fetch_pc_stage.sv | 93 +++++++++
 tb/tb_fetch_pc_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stage.sv
// Fetch stage: architectural fetch PC, instruction-memory address check,
// and the F/D pipeline register (IR, PC, delay-slot bit, ExcCode).
module fetch_pc_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6ffc,
    parameter logic [31:0] HANDLER  = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        Req,
    input  logic        eret_D,
    input  logic        branch_D,
    output logic [31:0] pc_F,
    output logic [31:0] IR_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic [31:0] pc8_D,
    output logic        BD_D,
    output logic [4:0]  exc_D
);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } fd_t;

    fd_t         fd_q;
    logic        adel_F;
    logic [31:0] instr_F;
    logic [4:0]  excF;

    // Bad fetch address: misaligned or outside IM (unsigned compares).
    // A faulting fetch never passes its IM word into D.
    always_comb begin
        adel_F  = (pc_F[1:0] != 2'b00) || (pc_F < IM_LO) || (pc_F > IM_HI);
        instr_F = adel_F ? 32'h0 : instr_in;
        excF    = adel_F ? EXC_ADEL : 5'd0;
    end

    // Fetch PC: exception redirect beats stall, stall holds, else follow NPC.
    always_ff @(posedge clk) begin
        if (reset)
            pc_F <= PC_RESET;
        else if (Req)
            pc_F <= HANDLER;
        else if (!stall)
            pc_F <= npc_in;
    end

    // F/D register: flush on Req, hold on stall, squash the F word behind
    // an eret (no delay slot), otherwise capture the checked fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q.ir  <= 32'h0;
            fd_q.pc  <= PC_RESET;
            fd_q.bd  <= 1'b0;
            fd_q.exc <= 5'd0;
        end else if (Req) begin
            fd_q.ir  <= 32'h0;
            fd_q.pc  <= HANDLER;
            fd_q.bd  <= 1'b0;
            fd_q.exc <= 5'd0;
        end else if (stall) begin
            fd_q <= fd_q;
        end else if (eret_D) begin
            fd_q.ir  <= 32'h0;
            fd_q.pc  <= pc_F;
            fd_q.bd  <= 1'b0;
            fd_q.exc <= 5'd0;
        end else begin
            fd_q.ir  <= instr_F;
            fd_q.pc  <= pc_F;
            fd_q.bd  <= branch_D;
            fd_q.exc <= excF;
        end
    end

    assign IR_D  = fd_q.ir;
    assign pc_D  = fd_q.pc;
    assign BD_D  = fd_q.bd;
    assign exc_D = fd_q.exc;
    // Link/return addresses for decode; plain 32-bit wrap-around.
    assign pc4_D = fd_q.pc + 32'd4;
    assign pc8_D = fd_q.pc + 32'd8;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed test-plan scenarios against fixed
// values, then randomized traffic against a transaction-level model.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc_in;
    logic [31:0] instr_in;
    logic        stall, Req, eret_D, branch_D;
    logic [31:0] pc_F, IR_D, pc_D, pc4_D, pc8_D;
    logic        BD_D;
    logic [4:0]  exc_D;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_pc, m_ir, m_pcd;
    logic        m_bd;
    logic [4:0]  m_exc;

    fetch_pc_stage dut (
        .clk(clk), .reset(reset), .npc_in(npc_in), .instr_in(instr_in),
        .stall(stall), .Req(Req), .eret_D(eret_D), .branch_D(branch_D),
        .pc_F(pc_F), .IR_D(IR_D), .pc_D(pc_D), .pc4_D(pc4_D), .pc8_D(pc8_D),
        .BD_D(BD_D), .exc_D(exc_D)
    );

    always #5 clk = ~clk;

    // instruction memory contents as a pure function of address
    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h3000) return 32'h2408_0001;
        if (a == 32'h3004) return 32'h2409_0002;
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) | 32'h1;
    endfunction

    assign instr_in = im_word(pc_F);

    function automatic logic [165:0] dut_vec();
        return {pc_F, IR_D, pc_D, pc4_D, pc8_D, BD_D, exc_D};
    endfunction

    function automatic logic [165:0] mdl_vec();
        return {m_pc, m_ir, m_pcd, m_pcd + 32'd4, m_pcd + 32'd8, m_bd, m_exc};
    endfunction

    // One clock: compute what the architecture should do this cycle, advance
    // the DUT, then commit the model. Outputs are sampled 1ns after the edge.
    task automatic tick();
        logic [31:0] n_pc, n_ir, n_pcd;
        logic        n_bd, bad;
        logic [4:0]  n_exc;
        bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6ffc);
        n_pc = m_pc; n_ir = m_ir; n_pcd = m_pcd; n_bd = m_bd; n_exc = m_exc;
        if (reset) begin
            n_pc = 32'h3000; n_ir = 0; n_pcd = 32'h3000; n_bd = 0; n_exc = 0;
        end else if (Req) begin
            n_pc = 32'h4180; n_ir = 0; n_pcd = 32'h4180; n_bd = 0; n_exc = 0;
        end else if (!stall) begin
            n_pc  = npc_in;
            n_pcd = m_pc;
            n_ir  = (eret_D || bad) ? 32'h0 : im_word(m_pc);
            n_bd  = eret_D ? 1'b0 : branch_D;
            n_exc = (!eret_D && bad) ? 5'd4 : 5'd0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_pcd = n_pcd; m_bd = n_bd; m_exc = n_exc;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; Req = 0; eret_D = 0; branch_D = 0;
        npc_in = m_pc + 32'd4;
    endtask

    task automatic test_reset();
        reset = 1; stall = 1; Req = 1; eret_D = 1; branch_D = 1; npc_in = 32'h1234_5678;
        m_pc = 32'hx; m_ir = 32'hx; m_pcd = 32'hx; m_bd = 1'bx; m_exc = 5'hx;
        tick();
        tick();
        checks++;
        if ({pc_F, IR_D, pc_D, BD_D, exc_D} !== {32'h3000, 32'h0, 32'h3000, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset: pc_F=%h IR_D=%h pc_D=%h BD_D=%b exc_D=%0d, want 3000/0/3000/0/0",
                     pc_F, IR_D, pc_D, BD_D, exc_D);
        end
    endtask

    task automatic test_free_run();
        idle_inputs();
        tick();
        checks++;
        if ({IR_D, pc_D, pc4_D, pc8_D, pc_F} !==
            {32'h2408_0001, 32'h3000, 32'h3004, 32'h3008, 32'h3004}) begin
            errors++;
            $display("FAIL free_run: IR_D=%h pc_D=%h pc4=%h pc8=%h pc_F=%h, want 24080001/3000/3004/3008/3004",
                     IR_D, pc_D, pc4_D, pc8_D, pc_F);
        end
        idle_inputs();
        tick();
        checks++;
        if ({IR_D, pc_F} !== {32'h2409_0002, 32'h3008}) begin
            errors++;
            $display("FAIL free_run2: IR_D=%h pc_F=%h, want 24090002/3008", IR_D, pc_F);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            stall = 1;
            tick();
            checks++;
            if ({pc_F, IR_D, pc_D, BD_D} !== {32'h3008, 32'h2409_0002, 32'h3004, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc_F=%h IR_D=%h pc_D=%h BD_D=%b, want 3008/24090002/3004/0",
                         i, pc_F, IR_D, pc_D, BD_D);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if ({pc_D, pc_F} !== {32'h3008, 32'h300c}) begin
            errors++;
            $display("FAIL stall_release: pc_D=%h pc_F=%h, want 3008/300c", pc_D, pc_F);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        branch_D = 1;
        tick();
        checks++;
        if ({BD_D, pc_D} !== {1'b1, 32'h300c}) begin
            errors++;
            $display("FAIL branch_bd: BD_D=%b pc_D=%h, want 1/300c", BD_D, pc_D);
        end
        idle_inputs();
        tick();
        checks++;
        if (BD_D !== 1'b0) begin
            errors++;
            $display("FAIL branch_clear: BD_D=%b, want 0", BD_D);
        end
    endtask

    task automatic test_adel();
        idle_inputs(); npc_in = 32'h3002; tick();
        idle_inputs(); npc_in = 32'h7000; tick();
        checks++;
        if ({IR_D, exc_D, pc_D, pc_F} !== {32'h0, 5'd4, 32'h3002, 32'h7000}) begin
            errors++;
            $display("FAIL adel_misaligned: IR_D=%h exc_D=%0d pc_D=%h pc_F=%h, want 0/4/3002/7000",
                     IR_D, exc_D, pc_D, pc_F);
        end
        idle_inputs(); npc_in = 32'h7004; tick();
        checks++;
        if ({IR_D, exc_D, pc_D} !== {32'h0, 5'd4, 32'h7000}) begin
            errors++;
            $display("FAIL adel_range: IR_D=%h exc_D=%0d pc_D=%h, want 0/4/7000", IR_D, exc_D, pc_D);
        end
        idle_inputs(); Req = 1; tick();
        checks++;
        if ({pc_F, IR_D, exc_D, pc_D} !== {32'h4180, 32'h0, 5'd0, 32'h4180}) begin
            errors++;
            $display("FAIL adel_req: pc_F=%h IR_D=%h exc_D=%0d pc_D=%h, want 4180/0/0/4180",
                     pc_F, IR_D, exc_D, pc_D);
        end
    endtask

    task automatic test_req_stall();
        idle_inputs(); npc_in = 32'h3010; tick();
        idle_inputs(); tick();
        idle_inputs(); Req = 1; stall = 1; branch_D = 1; tick();
        checks++;
        if ({pc_F, pc_D, IR_D, BD_D, exc_D} !== {32'h4180, 32'h4180, 32'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL req_stall: pc_F=%h pc_D=%h IR_D=%h BD_D=%b exc_D=%0d, want 4180/4180/0/0/0",
                     pc_F, pc_D, IR_D, BD_D, exc_D);
        end
    endtask

    task automatic test_eret();
        idle_inputs(); tick();  // pc_F 4184
        idle_inputs(); tick();  // pc_F 4188
        idle_inputs(); eret_D = 1; branch_D = 1; npc_in = 32'h3020; tick();
        checks++;
        if ({IR_D, pc_D, BD_D, exc_D, pc_F} !== {32'h0, 32'h4188, 1'b0, 5'd0, 32'h3020}) begin
            errors++;
            $display("FAIL eret: IR_D=%h pc_D=%h BD_D=%b exc_D=%0d pc_F=%h, want 0/4188/0/0/3020",
                     IR_D, pc_D, BD_D, exc_D, pc_F);
        end
        idle_inputs(); eret_D = 1; stall = 1; npc_in = 32'h5000; tick();
        checks++;
        if ({IR_D, pc_D, BD_D, pc_F} !== {32'h0, 32'h4188, 1'b0, 32'h3020}) begin
            errors++;
            $display("FAIL eret_stall: IR_D=%h pc_D=%h BD_D=%b pc_F=%h, want 0/4188/0/3020",
                     IR_D, pc_D, BD_D, pc_F);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            Req      = ($urandom_range(0, 19) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            eret_D   = ($urandom_range(0, 9) == 0);
            branch_D = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       npc_in = $urandom;
                1:       npc_in = 32'hffff_fffc;
                2:       npc_in = 32'h6ffc + 32'($urandom_range(0, 2)) * 4;
                3:       npc_in = 32'h3000 - 32'($urandom_range(0, 1)) * 4;
                4:       npc_in = 32'h3000 + ($urandom_range(0, 32'hfff) << 2) + 32'($urandom_range(0, 3));
                default: npc_in = m_pc + 32'd4;
            endcase
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs(); npc_in = 32'h3400; tick();
        idle_inputs(); tick();
        reset = 1; stall = 1; Req = 1; tick();
        checks++;
        if ({pc_F, IR_D, pc_D, exc_D, BD_D} !== {32'h3000, 32'h0, 32'h3000, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: pc_F=%h IR_D=%h pc_D=%h exc_D=%0d BD_D=%b, want 3000/0/3000/0/0",
                     pc_F, IR_D, pc_D, exc_D, BD_D);
        end
    endtask

    initial begin
        reset = 1; stall = 0; Req = 0; eret_D = 0; branch_D = 0; npc_in = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_adel();
        test_req_stall();
        test_eret();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
